fft_chann_flag_writer: RTL and testbench

//  Host-side driver for the FFT channel-flag config port (config_flag/config_num/config_en).

---
 rtl/fft_chann_flag_writer_if.sv | 24 ++
 rtl/fft_chann_flag_writer.sv | 110 +++++++++++
 tb/tb_fft_chann_flag_writer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_chann_flag_writer_if.sv
// Host-side shadow-RAM access plus the channel-flagger config strobe.
// The design drives the slave side. The host or the bench drives the master side.
interface fft_chann_flag_writer_if;
    logic [31:0] host_addr;
    logic [31:0] host_data;
    logic        host_we;
    logic        host_commit;
    logic [31:0] config_flag;
    logic [31:0] config_num;
    logic        config_en;
    logic        busy;
    logic        done;
    logic [31:0] commit_cnt;

    modport master (
        output host_addr, host_data, host_we, host_commit,
        input  config_flag, config_num, config_en, busy, done, commit_cnt
    );

    modport slave (
        input  host_addr, host_data, host_we, host_commit,
        output config_flag, config_num, config_en, busy, done, commit_cnt
    );
endinterface

// File: rtl/fft_chann_flag_writer.sv
// Streams a host-filled shadow RAM of channel-flag words to the FFT flagger on each commit edge.
// The first config_en comes 3 cycles after the commit edge, then one strobe every 3+GAP_CYCLES cycles. No backpressure; a commit during a pass queues one rerun.
module fft_chann_flag_writer #(
    parameter int FFT_SIZE   = 2048,
    parameter int GAP_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    fft_chann_flag_writer_if.slave bus
);
    localparam int WORDS = FFT_SIZE / 32;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, NEXT, DONE} state_t;

    state_t        state;
    logic [31:0]   ram [WORDS];
    logic [31:0]   rd_data;
    logic [AW-1:0] idx;
    logic [AW-1:0] waddr;
    logic [3:0]    gap_cnt;
    logic          commit_q;
    logic          pending;
    logic          commit_edge;
    logic          addr_ok;

    assign waddr       = bus.host_addr[AW-1:0];
    assign commit_edge = bus.host_commit & ~commit_q;

    generate
        if (WORDS == (1 << AW)) begin : g_pow2
            assign addr_ok = 1'b1;
        end else begin : g_npow2
            assign addr_ok = ({{(32-AW){1'b0}}, waddr} < 32'(WORDS));
        end
    endgenerate

    // No reset on the RAM. A write in the LOAD cycle of the same address returns the old word.
    always_ff @(posedge clk) begin
        if (bus.host_we && addr_ok)
            ram[waddr] <= bus.host_data;
        if (state == LOAD)
            rd_data <= ram[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            gap_cnt         <= '0;
            commit_q        <= 1'b0;
            pending         <= 1'b0;
            bus.config_flag <= '0;
            bus.config_num  <= '0;
            bus.config_en   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.commit_cnt  <= '0;
        end else begin
            commit_q      <= bus.host_commit;
            bus.config_en <= 1'b0;
            bus.done      <= 1'b0;
            if (commit_edge && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (commit_edge || pending) begin
                        state    <= LOAD;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        pending  <= 1'b0;
                    end
                end
                LOAD: state <= SEND;
                SEND: begin
                    bus.config_en   <= 1'b1;
                    bus.config_num  <= 32'(idx);
                    bus.config_flag <= rd_data;
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= 4'(GAP_CYCLES - 1);
                    end else begin
                        state <= NEXT;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0)
                        state <= NEXT;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end
                NEXT: begin
                    if (idx == AW'(WORDS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    bus.done       <= 1'b1;
                    bus.commit_cnt <= bus.commit_cnt + 32'd1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_chann_flag_writer.sv
// Bench for fft_chann_flag_writer. A pass-position model predicts every output each cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_fft_chann_flag_writer;
    localparam int WORDS = 64;
    localparam int G     = 2;
    localparam int P     = 3 + G;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_chann_flag_writer_if bus();

    fft_chann_flag_writer #(.FFT_SIZE(2048), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pass that starts at edge s reads word k at edge s+1+k*P.
    // It strobes that word at edge s+2+k*P and finishes at edge s+WORDS*P+1.
    logic [31:0] m_ram [WORDS];
    logic [31:0] m_rd, m_flag, m_num, m_cnt;
    logic        m_en, m_busy, m_done, m_prev, m_pend, m_active;
    int          m_start, edge_n, pos;
    logic        edge_det;

    initial begin
        edge_n = 0; m_active = 0; m_pend = 0; m_prev = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_en = 0; m_num = 0; m_flag = 0; m_busy = 0; m_done = 0; m_cnt = 0;
            m_active = 0; m_pend = 0; m_prev = 0;
        end else begin
            edge_det = bus.host_commit && !m_prev;
            m_prev   = bus.host_commit;
            m_en     = 0;
            m_done   = 0;
            if (m_active) begin
                pos = edge_n - m_start;
                if (edge_det) m_pend = 1;
                if (pos == WORDS * P + 1) begin
                    m_done = 1; m_cnt = m_cnt + 1; m_busy = 0; m_active = 0;
                end else if (pos >= 1 && (pos - 1) % P == 0) begin
                    m_rd = m_ram[(pos - 1) / P];
                end else if (pos >= 2 && (pos - 2) % P == 0) begin
                    m_en = 1; m_num = 32'((pos - 2) / P); m_flag = m_rd;
                end
            end else if (edge_det || m_pend) begin
                m_active = 1; m_start = edge_n; m_pend = 0; m_busy = 1;
            end
        end
        if (bus.host_we) m_ram[bus.host_addr[5:0]] = bus.host_data;
        edge_n++;
    end

    logic cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("config_en",   {31'd0, bus.config_en}, {31'd0, m_en});
            chk("config_num",  bus.config_num, m_num);
            chk("config_flag", bus.config_flag, m_flag);
            chk("busy",        {31'd0, bus.busy}, {31'd0, m_busy});
            chk("done",        {31'd0, bus.done}, {31'd0, m_done});
            chk("commit_cnt",  bus.commit_cnt, m_cnt);
        end
    end

    // Strobe recorder used by the literal checks
    logic [31:0] rec_num[$];
    logic [31:0] rec_flag[$];
    int          rec_cyc[$];
    int          cyc_n = 0, done_cnt = 0, busy_cyc = 0, commit_cyc = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (bus.config_en === 1'b1) begin
            rec_num.push_back(bus.config_num);
            rec_flag.push_back(bus.config_flag);
            rec_cyc.push_back(cyc_n);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        rec_num.delete(); rec_flag.delete(); rec_cyc.delete();
        done_cnt = 0; busy_cyc = 0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        bus.host_we = 1'b1; bus.host_addr = 32'(addr); bus.host_data = data;
        tick();
        bus.host_we = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.host_commit = 1'b1;
        @(negedge clk);
        #1 commit_cyc = cyc_n;
        tick();
        bus.host_commit = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (bus.done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) chk("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.host_addr = '0; bus.host_data = '0; bus.host_we = 1'b0; bus.host_commit = 1'b0;
        tick();
        cmp_on = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_en",   {31'd0, bus.config_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_cnt",  bus.commit_cnt, 32'd0);
        chk("rst_num",  bus.config_num, 32'd0);
        chk("rst_flag", bus.config_flag, 32'd0);

        // Full pass: ordering, data, latency, spacing, busy length
        for (int k = 0; k < WORDS; k++) wr(k, 32'hA5A5_0000 | 32'(k));
        clear_rec();
        pulse_commit();
        wait_done(700);
        repeat (3) tick();
        chk("t1_strobes", 32'(rec_num.size()), 32'd64);
        for (int k = 0; k < WORDS && k < rec_num.size(); k++) begin
            chk("t1_num",  rec_num[k], 32'(k));
            chk("t1_flag", rec_flag[k], 32'hA5A5_0000 | 32'(k));
        end
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);
        chk("t1_cnt", bus.commit_cnt, 32'd1);
        if (rec_cyc.size() == 64) begin
            chk("t2_latency",    32'(rec_cyc[0] - commit_cyc), 32'd3);
            chk("t2_spacing_01", 32'(rec_cyc[1] - rec_cyc[0]), 32'd5);
            chk("t2_spacing_63", 32'(rec_cyc[63] - rec_cyc[62]), 32'd5);
        end
        chk("t2_busy_cycles", 32'(busy_cyc), 32'd321);

        // Commit held high for 10 cycles yields one pass only
        clear_rec();
        bus.host_commit = 1'b1;
        repeat (10) tick();
        bus.host_commit = 1'b0;
        wait_done(700);
        repeat (15) tick();
        chk("t3_strobes", 32'(rec_num.size()), 32'd64);
        chk("t3_done_pulses", 32'(done_cnt), 32'd1);
        chk("t3_cnt", bus.commit_cnt, 32'd2);
        chk("t3_idle", {31'd0, bus.busy}, 32'd0);

        // Three commit edges during one pass coalesce into one extra pass
        do_reset();
        clear_rec();
        pulse_commit();
        repeat (3) begin
            repeat (30) tick();
            pulse_commit();
        end
        wait_done(700);
        wait_done(700);
        repeat (15) tick();
        chk("t4_cnt", bus.commit_cnt, 32'd2);
        chk("t4_done_pulses", 32'(done_cnt), 32'd2);
        chk("t4_strobes", 32'(rec_num.size()), 32'd128);

        // Writes mid-pass at idx 10: address 5 lands next pass, address 40 lands this pass
        clear_rec();
        pulse_commit();
        repeat (53) tick();
        wr(5, 32'h1);
        wr(40, 32'h2);
        wait_done(700);
        pulse_commit();
        wait_done(700);
        repeat (3) tick();
        chk("t5_strobes", 32'(rec_num.size()), 32'd128);
        if (rec_num.size() == 128) begin
            chk("t5_a_num5",   rec_num[5], 32'd5);
            chk("t5_a_flag5",  rec_flag[5], 32'hA5A5_0005);
            chk("t5_a_flag40", rec_flag[40], 32'h2);
            chk("t5_b_num5",   rec_num[69], 32'd5);
            chk("t5_b_flag5",  rec_flag[69], 32'h1);
            chk("t5_b_flag40", rec_flag[104], 32'h2);
        end

        // Reset at idx 20 aborts the pass
        do_reset();
        clear_rec();
        pulse_commit();
        repeat (103) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_en",   {31'd0, bus.config_en}, 32'd0);
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_cnt",  bus.commit_cnt, 32'd0);
        repeat (400) tick();
        chk("t6_done_pulses", 32'(done_cnt), 32'd0);
        chk("t6_strobes", 32'(rec_num.size()), 32'd21);
        chk("t6_cnt_after", bus.commit_cnt, 32'd0);
        clear_rec();
        pulse_commit();
        repeat (10) tick();
        chk("t6_restart_seen", {31'd0, rec_num.size() > 0}, 32'd1);
        if (rec_num.size() > 0) chk("t6_restart_num", rec_num[0], 32'd0);
        wait_done(700);
        repeat (3) tick();
        chk("t6_final_cnt", bus.commit_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
